// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch-queue definitions: instruction codes, status codes,
// fetch FSM states and the queue entry layout.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        FS_FETCH    = 2'd0,
        FS_WAIT_RET = 2'd1,
        FS_STOPPED  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valC;
        logic [63:0] valP;
        logic [2:0]  stat;
    } fq_entry_t;

    // Encoded length of a legal instruction; unknown codes count as one byte.
    function automatic logic [3:0] instr_length(input logic [3:0] icode);
        case (icode)
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: return 4'd2;
            IJXX, ICALL:                  return 4'd9;
            IIRMOVQ, IRMMOVQ, IMRMOVQ:    return 4'd10;
            default:                      return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/y86_predecode.sv
// Combinational predecode of one instruction: fields, status, length and
// predicted next PC (taken for jXX/call, fall-through otherwise).
module y86_predecode
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic [63:0] pc,
    input  logic [79:0] bytes,
    output fq_entry_t   entry,
    output logic [3:0]  length,
    output logic [63:0] pred_pc
);

    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic        fun_ok;
    logic        in_range;
    logic        ins;
    logic        adr;
    logic [64:0] end_addr;

    assign icode = bytes[7:4];
    assign ifun  = bytes[3:0];

    // Function-code legality for each instruction class.
    always_comb begin
        fun_ok = 1'b0;
        case (icode)
            IRRMOVQ, IJXX: fun_ok = (ifun <= 4'd6);
            IOPQ:          fun_ok = (ifun <= 4'd3);
            IHALT, INOP, IIRMOVQ, IRMMOVQ, IMRMOVQ,
            ICALL, IRET, IPUSHQ, IPOPQ:
                           fun_ok = (ifun == 4'd0);
            default:       fun_ok = 1'b0;
        endcase
    end

    // Byte 0 only means anything when the PC itself is inside memory.
    assign in_range = {1'b0, pc} < 65'(MEM_BYTES);
    assign ins      = in_range && !fun_ok;
    assign length   = ins ? 4'd1 : instr_length(icode);
    // 65-bit sum so a PC near 2^64 cannot wrap past the memory bound.
    assign end_addr = {1'b0, pc} + {61'd0, length};
    assign adr      = !in_range || (end_addr > 65'(MEM_BYTES));

    // Assemble the queue entry from the raw bytes.
    always_comb begin
        entry       = '0;
        entry.pc    = pc;
        entry.icode = icode;
        entry.ifun  = ifun;
        entry.rA    = RNONE;
        entry.rB    = RNONE;
        entry.valC  = 64'd0;
        if (length == 4'd2 || length == 4'd10) begin
            entry.rA = bytes[15:12];
            entry.rB = bytes[11:8];
        end
        if (length == 4'd9) begin
            entry.valC = bytes[71:8];
        end else if (length == 4'd10) begin
            entry.valC = bytes[79:16];
        end
        entry.valP = pc + {60'd0, length};
        if (adr) begin
            entry.stat = STAT_ADR;
        end else if (ins) begin
            entry.stat = STAT_INS;
        end else if (icode == IHALT) begin
            entry.stat = STAT_HLT;
        end else begin
            entry.stat = STAT_AOK;
        end
    end

    assign pred_pc = (!ins && (icode == IJXX || icode == ICALL)) ? entry.valC : entry.valP;

endmodule

// File: rtl/y86_fetch_queue.sv
// Decoupled Y86-64 fetch stage: predecodes one instruction per cycle,
// predicts the next PC and buffers entries in a BUF_DEPTH-deep FIFO.
//
// state       | meaning
// ------------+------------------------------------------------------
// FS_FETCH    | fetching, one push per cycle while the queue has room
// FS_WAIT_RET | ret fetched, target unknown; idle until redirect
// FS_STOPPED  | halt or fault fetched; idle until redirect
module y86_fetch_queue
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned BUF_DEPTH = 4,
    parameter logic [63:0] RESET_PC  = 64'd0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [63:0]                  imem_addr,
    input  logic [79:0]                  imem_bytes,
    input  logic                         redirect_valid,
    input  logic [63:0]                  redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [3:0]                   out_icode,
    output logic [3:0]                   out_ifun,
    output logic [3:0]                   out_rA,
    output logic [3:0]                   out_rB,
    output logic [63:0]                  out_valC,
    output logic [63:0]                  out_valP,
    output logic [63:0]                  out_pc,
    output logic [2:0]                   out_stat,
    output logic [$clog2(BUF_DEPTH):0]   count,
    output logic [63:0]                  fetch_pc
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    fetch_state_t  state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    fq_entry_t     buf_q [BUF_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push, pop, flush;

    fq_entry_t     pd_entry;
    logic [3:0]    pd_len_unused;
    logic [63:0]   pd_pred_pc;
    fq_entry_t     head;

    y86_predecode #(
        .MEM_BYTES(MEM_BYTES)
    ) u_predecode (
        .pc     (pc_q),
        .bytes  (imem_bytes),
        .entry  (pd_entry),
        .length (pd_len_unused),
        .pred_pc(pd_pred_pc)
    );

    // FSM and PC state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state, next PC and queue push/pop/flush decisions.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        if (redirect_valid) begin
            flush   = 1'b1;
            state_d = FS_FETCH;
            pc_d    = redirect_pc;
        end else begin
            pop = (count_q != '0) && out_ready;
            case (state_q)
                FS_FETCH: begin
                    if (count_q < CW'(BUF_DEPTH)) begin
                        push = 1'b1;
                        if (pd_entry.stat != STAT_AOK) begin
                            state_d = FS_STOPPED;
                        end else if (pd_entry.icode == IRET) begin
                            state_d = FS_WAIT_RET;
                        end else begin
                            pc_d = pd_pred_pc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; data needs no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= pd_entry;
        end
    end

    // Head view: an empty queue presents zero fields with AOK status.
    always_comb begin
        head      = '0;
        head.stat = STAT_AOK;
        if (count_q != '0) begin
            head = buf_q[rd_ptr_q];
        end
    end

    assign out_valid = (count_q != '0);
    assign out_icode = head.icode;
    assign out_ifun  = head.ifun;
    assign out_rA    = head.rA;
    assign out_rB    = head.rB;
    assign out_valC  = head.valC;
    assign out_valP  = head.valP;
    assign out_pc    = head.pc;
    assign out_stat  = head.stat;
    assign count     = count_q;
    assign fetch_pc  = pc_q;
    assign imem_addr = pc_q;

endmodule

// File: tb/tb_y86_fetch_queue.sv
// Self-checking bench for y86_fetch_queue: directed scenarios plus a
// randomized run against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_y86_fetch_queue;
    import y86_pkg::*;

    localparam int unsigned MEM_BYTES = 1024;
    localparam int unsigned BUF_DEPTH = 4;
    localparam logic [63:0] RESET_PC  = 64'd0;
    localparam int          CW        = $clog2(BUF_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   imem_addr;
    logic [79:0]   imem_bytes;
    logic          redirect_valid;
    logic [63:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_icode, out_ifun, out_rA, out_rB;
    logic [63:0]   out_valC, out_valP, out_pc;
    logic [2:0]    out_stat;
    logic [CW-1:0] count;
    logic [63:0]   fetch_pc;

    logic [7:0]    mem [MEM_BYTES];
    logic [63:0]   byte_addr [10];
    fq_entry_t     pops [$];
    int            starts [$];
    int            n_checks = 0;
    int            n_fail   = 0;

    y86_fetch_queue #(
        .MEM_BYTES(MEM_BYTES),
        .BUF_DEPTH(BUF_DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_bytes    (imem_bytes),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_icode     (out_icode),
        .out_ifun      (out_ifun),
        .out_rA        (out_rA),
        .out_rB        (out_rB),
        .out_valC      (out_valC),
        .out_valP      (out_valP),
        .out_pc        (out_pc),
        .out_stat      (out_stat),
        .count         (count),
        .fetch_pc      (fetch_pc)
    );

    always #5 clk = ~clk;

    for (genvar k = 0; k < 10; k++) begin : g_imem
        assign byte_addr[k] = imem_addr + 64'(k);
        assign imem_bytes[8*k +: 8] = (byte_addr[k] < 64'(MEM_BYTES)) ? mem[byte_addr[k][9:0]] : 8'h00;
    end

    function automatic logic [7:0] tb_byte(input logic [63:0] a);
        if (a < 64'(MEM_BYTES)) return mem[a[9:0]];
        return 8'h00;
    endfunction

    function automatic fq_entry_t head_now();
        fq_entry_t h;
        h.pc = out_pc; h.icode = out_icode; h.ifun = out_ifun;
        h.rA = out_rA; h.rB = out_rB; h.valC = out_valC;
        h.valP = out_valP; h.stat = out_stat;
        return h;
    endfunction

    // Reference decode straight from the instruction-set rules.
    function automatic fq_entry_t ref_decode(input logic [63:0] pc);
        fq_entry_t e;
        logic [7:0] b0, b1;
        int len;
        int off;
        bit legal;
        bit in_mem;
        bit ins;
        b0 = tb_byte(pc);
        b1 = tb_byte(pc + 64'd1);
        e = '0;
        e.pc = pc; e.icode = b0[7:4]; e.ifun = b0[3:0];
        e.rA = 4'hF; e.rB = 4'hF;
        case (b0[7:4])
            4'h0, 4'h1, 4'h9: begin len = 1;  legal = (b0[3:0] == 0); end
            4'h2:             begin len = 2;  legal = (b0[3:0] <= 6);  end
            4'h3, 4'h4, 4'h5: begin len = 10; legal = (b0[3:0] == 0); end
            4'h6:             begin len = 2;  legal = (b0[3:0] <= 3);  end
            4'h7:             begin len = 9;  legal = (b0[3:0] <= 6);  end
            4'h8:             begin len = 9;  legal = (b0[3:0] == 0); end
            4'hA, 4'hB:       begin len = 2;  legal = (b0[3:0] == 0); end
            default:          begin len = 1;  legal = 0;               end
        endcase
        in_mem = (pc < 64'(MEM_BYTES));
        ins = in_mem && !legal;
        if (ins) len = 1;
        if (len == 2 || len == 10) begin
            e.rA = b1[7:4];
            e.rB = b1[3:0];
        end
        if (len >= 9) begin
            off = (len == 9) ? 1 : 2;
            for (int i = 0; i < 8; i++) e.valC[8*i +: 8] = tb_byte(pc + 64'(off + i));
        end
        e.valP = pc + 64'(len);
        if (!in_mem || ({1'b0, pc} + 65'(len) > 65'(MEM_BYTES))) e.stat = STAT_ADR;
        else if (ins) e.stat = STAT_INS;
        else if (b0[7:4] == 4'h0) e.stat = STAT_HLT;
        else e.stat = STAT_AOK;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 64'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_mem(input logic [7:0] b);
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = b;
    endtask

    task automatic run_collect(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (out_valid && out_ready) pops.push_back(head_now());
            tick();
        end
    endtask

    task automatic test_reset();
        fill_mem(8'h10);
        out_ready = 1'b0;
        reset_dut();
        n_checks++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++; if (fetch_pc !== RESET_PC) begin n_fail++; $display("FAIL reset_fetch_pc: got %h want %h", fetch_pc, RESET_PC); end
        n_checks++; if (out_stat !== STAT_AOK) begin n_fail++; $display("FAIL reset_stat: got %0d want %0d", out_stat, STAT_AOK); end
        n_checks++; if ({out_pc, out_icode, out_valC, out_valP} !== '0) begin n_fail++; $display("FAIL reset_fields: pc %h icode %h valC %h valP %h want 0", out_pc, out_icode, out_valC, out_valP); end
    endtask

    task automatic test_straight_line();
        logic [63:0] exp_pc [4]   = '{64'd0, 64'd10, 64'd12, 64'd13};
        logic [63:0] exp_valp [4] = '{64'd10, 64'd12, 64'd13, 64'd14};
        logic [2:0]  exp_stat [4] = '{STAT_AOK, STAT_AOK, STAT_AOK, STAT_HLT};
        fill_mem(8'h00);
        mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h08;
        mem[10] = 8'h60; mem[11] = 8'h30; mem[12] = 8'h10; mem[13] = 8'h00;
        out_ready = 1'b1;
        reset_dut();
        pops.delete();
        run_collect(8);
        n_checks++; if (pops.size() != 4) begin n_fail++; $display("FAIL line_pop_count: got %0d want 4", pops.size()); end
        for (int i = 0; i < 4 && i < pops.size(); i++) begin
            n_checks++; if (pops[i].pc !== exp_pc[i] || pops[i].valP !== exp_valp[i] || pops[i].stat !== exp_stat[i]) begin
                n_fail++; $display("FAIL line_pop%0d: got pc %0d valP %0d stat %0d want pc %0d valP %0d stat %0d",
                    i, pops[i].pc, pops[i].valP, pops[i].stat, exp_pc[i], exp_valp[i], exp_stat[i]);
            end
        end
        if (pops.size() > 0) begin
            n_checks++; if (pops[0].valC !== 64'd8 || pops[0].rA !== 4'hF || pops[0].rB !== 4'h3) begin
                n_fail++; $display("FAIL line_irmovq: got valC %0d rA %h rB %h want 8 F 3", pops[0].valC, pops[0].rA, pops[0].rB);
            end
        end
        n_checks++; if (fetch_pc !== 64'd13) begin n_fail++; $display("FAIL line_fetch_pc: got %0d want 13", fetch_pc); end
        n_checks++; if (dut.state_q !== FS_STOPPED) begin n_fail++; $display("FAIL line_state: got %0d want %0d", dut.state_q, FS_STOPPED); end
    endtask

    task automatic test_prediction();
        fill_mem(8'h00);
        mem[0] = 8'h70; mem[1] = 8'h20;
        for (int i = 32; i < 48; i++) mem[i] = 8'h10;
        out_ready = 1'b0;
        reset_dut();
        tick();
        n_checks++; if (fetch_pc !== 64'h20) begin n_fail++; $display("FAIL pred_target: got %h want 20", fetch_pc); end
        n_checks++; if (out_icode !== IJXX || out_valC !== 64'h20 || out_valP !== 64'd9) begin
            n_fail++; $display("FAIL pred_head: got icode %h valC %h valP %0d want 7 20 9", out_icode, out_valC, out_valP);
        end
        tick();
        n_checks++; if (fetch_pc !== 64'h21 || count !== CW'(2)) begin n_fail++; $display("FAIL pred_second: got fetch_pc %h count %0d want 21 2", fetch_pc, count); end
        redirect_valid = 1'b1; redirect_pc = 64'd9; out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; out_ready = 1'b0;
        n_checks++; if (count !== '0 || out_valid !== 1'b0 || fetch_pc !== 64'd9) begin
            n_fail++; $display("FAIL pred_flush: got count %0d valid %b fetch_pc %0d want 0 0 9", count, out_valid, fetch_pc);
        end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 64'd9 || out_stat !== STAT_HLT) begin
            n_fail++; $display("FAIL pred_after_redirect: got valid %b pc %0d stat %0d want 1 9 %0d", out_valid, out_pc, out_stat, STAT_HLT);
        end
    endtask

    task automatic test_backpressure();
        fill_mem(8'h00);
        for (int i = 0; i < 6; i++) mem[i] = 8'h10;
        out_ready = 1'b0;
        reset_dut();
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (count !== CW'(BUF_DEPTH)) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", count, BUF_DEPTH); end
        n_checks++; if (fetch_pc !== 64'd4) begin n_fail++; $display("FAIL bp_fetch_pc: got %0d want 4", fetch_pc); end
        out_ready = 1'b1;
        pops.delete();
        run_collect(12);
        n_checks++; if (pops.size() != 7) begin n_fail++; $display("FAIL bp_pop_count: got %0d want 7", pops.size()); end
        for (int i = 0; i < pops.size(); i++) begin
            n_checks++; if (pops[i].pc !== 64'(i)) begin n_fail++; $display("FAIL bp_order%0d: got pc %0d want %0d", i, pops[i].pc, i); end
        end
    endtask

    task automatic test_errors();
        fill_mem(8'h00);
        mem[0] = 8'hC0;
        out_ready = 1'b0;
        reset_dut();
        tick();
        n_checks++; if (out_stat !== STAT_INS || out_valP !== 64'd1) begin n_fail++; $display("FAIL err_ins: got stat %0d valP %0d want %0d 1", out_stat, out_valP, STAT_INS); end
        n_checks++; if (dut.state_q !== FS_STOPPED) begin n_fail++; $display("FAIL err_ins_state: got %0d want %0d", dut.state_q, FS_STOPPED); end
        tick(); tick();
        n_checks++; if (count !== CW'(1) || fetch_pc !== 64'd0) begin n_fail++; $display("FAIL err_ins_hold: got count %0d fetch_pc %0d want 1 0", count, fetch_pc); end

        fill_mem(8'h00);
        mem[MEM_BYTES-5] = 8'h30; mem[MEM_BYTES-4] = 8'hF3;
        reset_dut();
        redirect_valid = 1'b1; redirect_pc = 64'(MEM_BYTES - 5);
        tick();
        redirect_valid = 1'b0;
        tick();
        n_checks++; if (out_pc !== 64'(MEM_BYTES - 5) || out_stat !== STAT_ADR) begin
            n_fail++; $display("FAIL err_adr_tail: got pc %0d stat %0d want %0d %0d", out_pc, out_stat, MEM_BYTES - 5, STAT_ADR);
        end
        n_checks++; if (dut.state_q !== FS_STOPPED) begin n_fail++; $display("FAIL err_adr_tail_state: got %0d want %0d", dut.state_q, FS_STOPPED); end

        reset_dut();
        redirect_valid = 1'b1; redirect_pc = 64'(MEM_BYTES);
        tick();
        redirect_valid = 1'b0;
        tick();
        n_checks++; if (out_pc !== 64'(MEM_BYTES) || out_stat !== STAT_ADR || count !== CW'(1)) begin
            n_fail++; $display("FAIL err_adr_pc: got pc %0d stat %0d count %0d want %0d %0d 1", out_pc, out_stat, count, MEM_BYTES, STAT_ADR);
        end
        n_checks++; if (dut.state_q !== FS_STOPPED) begin n_fail++; $display("FAIL err_adr_pc_state: got %0d want %0d", dut.state_q, FS_STOPPED); end
    endtask

    task automatic test_corners();
        fill_mem(8'h10);
        mem[0] = 8'h90;
        out_ready = 1'b1;
        reset_dut();
        tick();
        n_checks++; if (out_icode !== IRET || dut.state_q !== FS_WAIT_RET) begin
            n_fail++; $display("FAIL ret_enter: got icode %h state %0d want 9 %0d", out_icode, dut.state_q, FS_WAIT_RET);
        end
        pops.delete();
        run_collect(6);
        n_checks++; if (pops.size() != 1 || fetch_pc !== 64'd0 || count !== '0) begin
            n_fail++; $display("FAIL ret_idle: got pops %0d fetch_pc %0d count %0d want 1 0 0", pops.size(), fetch_pc, count);
        end

        fill_mem(8'h10);
        out_ready = 1'b1;
        reset_dut();
        tick(); tick();
        n_checks++; if (count !== CW'(1) || out_valid !== 1'b1) begin n_fail++; $display("FAIL redir_pre: got count %0d valid %b want 1 1", count, out_valid); end
        redirect_valid = 1'b1; redirect_pc = 64'd40;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (count !== '0 || out_valid !== 1'b0 || fetch_pc !== 64'd40) begin
            n_fail++; $display("FAIL redir_flush: got count %0d valid %b fetch_pc %0d want 0 0 40", count, out_valid, fetch_pc);
        end
        tick();
        n_checks++; if (out_pc !== 64'd40 || count !== CW'(1)) begin n_fail++; $display("FAIL redir_restart: got pc %0d count %0d want 40 1", out_pc, count); end

        out_ready = 1'b0;
        reset_dut();
        tick(); tick(); tick();
        n_checks++; if (count !== CW'(3)) begin n_fail++; $display("FAIL midrst_pre: got count %0d want 3", count); end
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'd77;
        tick();
        rst = 1'b0; redirect_valid = 1'b0;
        n_checks++; if (count !== '0 || out_valid !== 1'b0 || fetch_pc !== RESET_PC || out_stat !== STAT_AOK) begin
            n_fail++; $display("FAIL midrst: got count %0d valid %b fetch_pc %0d stat %0d want 0 0 %0d %0d", count, out_valid, fetch_pc, out_stat, RESET_PC, STAT_AOK);
        end
    endtask

    task automatic gen_program();
        int a;
        a = 0;
        starts.delete();
        fill_mem(8'h00);
        while (a < MEM_BYTES) begin
            logic [3:0] ic;
            logic [3:0] fn;
            logic [63:0] tgt;
            int len;
            starts.push_back(a);
            ic = 4'($urandom_range(0, 11));
            case (ic)
                4'h2, 4'h7: fn = 4'($urandom_range(0, 6));
                4'h6:       fn = 4'($urandom_range(0, 3));
                default:    fn = 4'h0;
            endcase
            mem[a] = {ic, fn};
            if ($urandom_range(0, 15) == 0) mem[a] = 8'($urandom_range(0, 255));
            case (ic)
                4'h2, 4'h6, 4'hA, 4'hB: len = 2;
                4'h7, 4'h8:             len = 9;
                4'h3, 4'h4, 4'h5:       len = 10;
                default:                len = 1;
            endcase
            for (int i = 1; i < len; i++) if (a + i < MEM_BYTES) mem[a+i] = 8'($urandom_range(0, 255));
            if (len == 9) begin
                tgt = 64'(starts[$urandom_range(0, starts.size() - 1)]);
                for (int i = 0; i < 8; i++) if (a + 1 + i < MEM_BYTES) mem[a+1+i] = tgt[8*i +: 8];
            end
            a += len;
        end
    endtask

    task automatic test_random();
        fq_entry_t q [$];
        fq_entry_t e;
        logic [63:0] mpc;
        int mode;
        bit do_pop;
        bit do_push;
        gen_program();
        out_ready = 1'b0;
        reset_dut();
        mpc = RESET_PC;
        mode = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            n_checks++; if (count !== CW'(q.size())) begin n_fail++; $display("FAIL rand_count cyc %0d: got %0d want %0d", cyc, count, q.size()); end
            n_checks++; if (fetch_pc !== mpc) begin n_fail++; $display("FAIL rand_fetch_pc cyc %0d: got %h want %h", cyc, fetch_pc, mpc); end
            n_checks++; if (out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                n_checks++; if (head_now() !== q[0]) begin n_fail++; $display("FAIL rand_head cyc %0d: got %h want %h", cyc, head_now(), q[0]); end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) != 0) redirect_pc = 64'(starts[$urandom_range(0, starts.size() - 1)]);
            else redirect_pc = 64'($urandom_range(0, MEM_BYTES + 16));
            if (redirect_valid) begin
                q.delete();
                mpc = redirect_pc;
                mode = 0;
            end else begin
                do_pop = (q.size() > 0) && out_ready;
                do_push = (mode == 0) && (q.size() < BUF_DEPTH);
                if (do_pop) void'(q.pop_front());
                if (do_push) begin
                    e = ref_decode(mpc);
                    q.push_back(e);
                    if (e.stat != STAT_AOK) mode = 2;
                    else if (e.icode == IRET) mode = 1;
                    else if (e.icode == IJXX || e.icode == ICALL) mpc = e.valC;
                    else mpc = e.valP;
                end
            end
            tick();
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 64'd0;
        test_reset();
        test_straight_line();
        test_prediction();
        test_backpressure();
        test_errors();
        test_corners();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
